byteswap_job_sequencer: RTL and testbench

- Job scheduler in front of the byteswap datapath's AXI read master and AXI write master.
- Accepts queued in-place swap jobs (offset, length) from the control layer.
- Splits each job into chunks of at most C_CHUNK_BYTES. Each chunk issues one ctrl_start pair to both masters, and the block waits for both ctrl_done pulses before issuing the next chunk.
- Emits one job_done pulse per job; replaces the direct ap_start_pulse fan-out.

---
 rtl/byteswap_seq_pkg.sv | 28 ++
 rtl/byteswap_job_fifo.sv | 68 ++++++
 rtl/byteswap_job_sequencer.sv | 149 ++++++++++++++
 tb/tb_byteswap_job_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byteswap_seq_pkg.sv
// Shared types for the byteswap job sequencer: FSM states, queued job record
// and the chunk sizing helper.
package byteswap_seq_pkg;

    localparam int unsigned SEQ_ADDR_W = 64;
    localparam int unsigned SEQ_LEN_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_ADDR_W-1:0] offset;
        logic [SEQ_LEN_W-1:0]  length;
    } job_t;

    function automatic logic [SEQ_LEN_W-1:0] chunk_len(
        input logic [SEQ_LEN_W-1:0] remaining,
        input logic [SEQ_LEN_W-1:0] max_chunk
    );
        return (remaining < max_chunk) ? remaining : max_chunk;
    endfunction

endpackage

// File: rtl/byteswap_job_fifo.sv
// Synchronous job queue with registered full/empty flags; a push and a pop in
// the same cycle are both honoured and leave the occupancy unchanged.
module byteswap_job_fifo
    import byteswap_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic ap_clk,
    input  logic areset,
    input  logic push,
    input  job_t push_data,
    input  logic pop,
    output job_t pop_data,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    job_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + (PTR_W+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - (PTR_W+1)'(1);
        end
    end

    // Storage is not reset; only pointers and flags define validity.
    always_ff @(posedge ap_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == (PTR_W+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/byteswap_job_sequencer.sv
// Queues in-place swap jobs and feeds them to the AXI read/write masters as
// chunks, waiting for both masters to finish each chunk before the next one.
//
// state | meaning
// IDLE  | waiting for a queued job; pops it when present
// LOAD  | picks the next chunk, or finishes the job when nothing remains
// ISSUE | one-cycle start pulse to both masters
// WAIT  | collecting both done pulses (any order)
// DONE  | one-cycle job_done pulse
module byteswap_job_sequencer
    import byteswap_seq_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH   = 64,
    parameter int unsigned C_LENGTH_WIDTH = 32,
    parameter int unsigned C_CHUNK_BYTES  = 1048576,
    parameter int unsigned C_QUEUE_DEPTH  = 4
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [C_ADDR_WIDTH-1:0]   job_offset,
    input  logic [C_LENGTH_WIDTH-1:0] job_length,
    output logic                      rd_ctrl_start,
    output logic [C_ADDR_WIDTH-1:0]   rd_ctrl_offset,
    output logic [C_LENGTH_WIDTH-1:0] rd_ctrl_length,
    input  logic                      rd_ctrl_done,
    output logic                      wr_ctrl_start,
    output logic [C_ADDR_WIDTH-1:0]   wr_ctrl_offset,
    output logic [C_LENGTH_WIDTH-1:0] wr_ctrl_length,
    input  logic                      wr_ctrl_done,
    output logic                      job_done,
    output logic                      busy,
    output logic [15:0]               jobs_completed
);

    seq_state_t                state;
    job_t                      fifo_din;
    job_t                      fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [C_ADDR_WIDTH-1:0]   cur_off;
    logic [C_LENGTH_WIDTH-1:0] remaining;
    logic [C_LENGTH_WIDTH-1:0] chunk;
    logic [C_LENGTH_WIDTH-1:0] chunk_next;
    logic                      rd_seen;
    logic                      wr_seen;
    logic                      rd_now;
    logic                      wr_now;
    logic                      ctrl_start;
    logic [C_ADDR_WIDTH-1:0]   ctrl_offset;
    logic [C_LENGTH_WIDTH-1:0] ctrl_length;

    assign fifo_din.offset = SEQ_ADDR_W'(job_offset);
    assign fifo_din.length = SEQ_LEN_W'(job_length);
    assign fifo_push       = job_valid && job_ready;
    assign fifo_pop        = (state == ST_IDLE) && !fifo_empty;

    byteswap_job_fifo #(
        .DEPTH (C_QUEUE_DEPTH)
    ) u_job_fifo (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign job_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    // Both masters always work on the same chunk, so they share one register set.
    assign rd_ctrl_start  = ctrl_start;
    assign wr_ctrl_start  = ctrl_start;
    assign rd_ctrl_offset = ctrl_offset;
    assign wr_ctrl_offset = ctrl_offset;
    assign rd_ctrl_length = ctrl_length;
    assign wr_ctrl_length = ctrl_length;

    assign chunk_next = C_LENGTH_WIDTH'(chunk_len(SEQ_LEN_W'(remaining), SEQ_LEN_W'(C_CHUNK_BYTES)));
    assign rd_now     = rd_seen || rd_ctrl_done;
    assign wr_now     = wr_seen || wr_ctrl_done;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state          <= ST_IDLE;
            cur_off        <= '0;
            remaining      <= '0;
            chunk          <= '0;
            rd_seen        <= 1'b0;
            wr_seen        <= 1'b0;
            ctrl_start     <= 1'b0;
            ctrl_offset    <= '0;
            ctrl_length    <= '0;
            job_done       <= 1'b0;
            jobs_completed <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_off   <= C_ADDR_WIDTH'(fifo_dout.offset);
                        remaining <= C_LENGTH_WIDTH'(fifo_dout.length);
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (remaining == '0) begin
                        job_done       <= 1'b1;
                        jobs_completed <= jobs_completed + 16'd1;
                        state          <= ST_DONE;
                    end else begin
                        chunk       <= chunk_next;
                        ctrl_offset <= cur_off;
                        ctrl_length <= chunk_next;
                        ctrl_start  <= 1'b1;
                        rd_seen     <= 1'b0;
                        wr_seen     <= 1'b0;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ctrl_start <= 1'b0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rd_now && wr_now) begin
                        cur_off   <= cur_off + C_ADDR_WIDTH'(chunk);
                        remaining <= remaining - chunk;
                        state     <= ST_LOAD;
                    end else begin
                        rd_seen <= rd_now;
                        wr_seen <= wr_now;
                    end
                end
                ST_DONE: begin
                    job_done <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byteswap_job_sequencer.sv
// Directed bench for byteswap_job_sequencer with a 4 KiB chunk and a 4-deep queue.
module tb_byteswap_job_sequencer;

    localparam int AW = 64;
    localparam int LW = 32;

    logic          ap_clk;
    logic          areset;
    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] job_offset;
    logic [LW-1:0] job_length;
    logic          rd_ctrl_start;
    logic [AW-1:0] rd_ctrl_offset;
    logic [LW-1:0] rd_ctrl_length;
    logic          rd_ctrl_done;
    logic          wr_ctrl_start;
    logic [AW-1:0] wr_ctrl_offset;
    logic [LW-1:0] wr_ctrl_length;
    logic          wr_ctrl_done;
    logic          job_done;
    logic          busy;
    logic [15:0]   jobs_completed;

    byteswap_job_sequencer #(
        .C_ADDR_WIDTH   (AW),
        .C_LENGTH_WIDTH (LW),
        .C_CHUNK_BYTES  (4096),
        .C_QUEUE_DEPTH  (4)
    ) dut (
        .ap_clk         (ap_clk),
        .areset         (areset),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_offset     (job_offset),
        .job_length     (job_length),
        .rd_ctrl_start  (rd_ctrl_start),
        .rd_ctrl_offset (rd_ctrl_offset),
        .rd_ctrl_length (rd_ctrl_length),
        .rd_ctrl_done   (rd_ctrl_done),
        .wr_ctrl_start  (wr_ctrl_start),
        .wr_ctrl_offset (wr_ctrl_offset),
        .wr_ctrl_length (wr_ctrl_length),
        .wr_ctrl_done   (wr_ctrl_done),
        .job_done       (job_done),
        .busy           (busy),
        .jobs_completed (jobs_completed)
    );

    typedef struct {
        int            cyc;
        logic          rd_start;
        logic          wr_start;
        logic [AW-1:0] rd_off;
        logic [AW-1:0] wr_off;
        logic [LW-1:0] rd_len;
        logic [LW-1:0] wr_len;
    } start_t;

    typedef struct {
        logic          new_job;
        logic [AW-1:0] job_off;
        logic [LW-1:0] job_len;
        logic [AW-1:0] exp_off;
        logic [LW-1:0] exp_len;
        int            rd_dly;
        int            wr_dly;
        logic          last;
    } vec_t;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    int     n_acc    = 0;
    start_t st_q[$];
    int     done_q[$];
    vec_t   vecs[$];

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Passive monitor: records every start pulse, job_done pulse and accepted push.
    always @(negedge ap_clk) begin
        if (rd_ctrl_start === 1'b1 || wr_ctrl_start === 1'b1) begin
            st_q.push_back('{cyc, rd_ctrl_start, wr_ctrl_start, rd_ctrl_offset,
                             wr_ctrl_offset, rd_ctrl_length, wr_ctrl_length});
        end
        if (job_done === 1'b1) done_q.push_back(cyc);
        if (job_valid === 1'b1 && job_ready === 1'b1) n_acc = n_acc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic add_vec(input logic nj, input logic [AW-1:0] joff, input logic [LW-1:0] jlen,
                           input logic [AW-1:0] eoff, input logic [LW-1:0] elen,
                           input int rd, input int wr, input logic last);
        vecs.push_back('{nj, joff, jlen, eoff, elen, rd, wr, last});
    endtask

    // Caller is just after a rising edge; returns just after the edge following acceptance.
    task automatic push_job(input logic [AW-1:0] off, input logic [LW-1:0] len, output int acc);
        job_offset = off;
        job_length = len;
        job_valid  = 1'b1;
        acc        = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge ap_clk);
            if (job_ready === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        @(posedge ap_clk);
        #1;
        job_valid = 1'b0;
        if (acc < 0) chk_int("push_timeout", acc, 0);
    endtask

    task automatic get_start(output start_t r);
        r = '{-1, 1'b0, 1'b0, '0, '0, '0, '0};
        for (int k = 0; k < 200; k++) begin
            if (st_q.size() > 0) begin
                r = st_q.pop_front();
                return;
            end
            @(negedge ap_clk);
            #1;
        end
        chk_int("start_timeout", -1, 0);
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int k = 0; k < 200; k++) begin
            if (done_q.size() > 0) begin
                d = done_q.pop_front();
                return;
            end
            @(negedge ap_clk);
            #1;
        end
        chk_int("job_done_timeout", -1, 0);
    endtask

    // Pulses each done input k cycles from now; m is the cycle of the later pulse.
    task automatic do_dones(input int rd, input int wr, output int m);
        int d;
        d = (rd > wr) ? rd : wr;
        m = -1;
        for (int k = 1; k <= d; k++) begin
            step();
            rd_ctrl_done = (k == rd);
            wr_ctrl_done = (k == wr);
            if (k == d) m = cyc;
        end
        step();
        rd_ctrl_done = 1'b0;
        wr_ctrl_done = 1'b0;
    endtask

    task automatic chk_start(input string name, input start_t r, input logic [AW-1:0] off,
                             input logic [LW-1:0] len, input int exp_cyc);
        if (exp_cyc >= 0) chk_int({name, "_cycle"}, r.cyc, exp_cyc);
        chk({name, "_both_start"}, {62'd0, r.rd_start, r.wr_start}, 64'd3);
        chk({name, "_rd_off"}, r.rd_off, off);
        chk({name, "_wr_off"}, r.wr_off, off);
        chk({name, "_rd_len"}, 64'(r.rd_len), 64'(len));
        chk({name, "_wr_len"}, 64'(r.wr_len), 64'(len));
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_rd_start"}, 64'(rd_ctrl_start), 64'd0);
        chk({name, "_wr_start"}, 64'(wr_ctrl_start), 64'd0);
        chk({name, "_job_done"}, 64'(job_done), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_job_ready"}, 64'(job_ready), 64'd1);
        chk({name, "_jobs_completed"}, 64'(jobs_completed), 64'd0);
        chk({name, "_rd_off"}, rd_ctrl_offset, 64'd0);
        chk({name, "_wr_off"}, wr_ctrl_offset, 64'd0);
        chk({name, "_rd_len"}, 64'(rd_ctrl_length), 64'd0);
        chk({name, "_wr_len"}, 64'(wr_ctrl_length), 64'd0);
    endtask

    initial begin
        start_t        r;
        vec_t          v;
        int            acc;
        int            m;
        int            d;
        int            d0;
        int            exp_start;
        logic [15:0]   jc;
        logic [AW-1:0] f_off[6];
        logic [LW-1:0] f_len[6];

        areset       = 1'b1;
        job_valid    = 1'b0;
        job_offset   = '0;
        job_length   = '0;
        rd_ctrl_done = 1'b0;
        wr_ctrl_done = 1'b0;
        jc           = '0;
        exp_start    = -1;

        //       new   job_off                 job_len  exp_off                 exp_len rd  wr  last
        add_vec(1'b1, 64'h1000,               32'd4096,  64'h1000,               32'd4096, 20, 20, 1'b1);
        add_vec(1'b1, 64'h0,                  32'd10000, 64'h0,                  32'd4096,  3,  3, 1'b0);
        add_vec(1'b0, 64'h0,                  32'd0,     64'h1000,               32'd4096,  4,  4, 1'b0);
        add_vec(1'b0, 64'h0,                  32'd0,     64'h2000,               32'd1808,  2,  2, 1'b1);
        add_vec(1'b1, 64'h8000,               32'd8192,  64'h8000,               32'd4096, 25, 20, 1'b0);
        add_vec(1'b0, 64'h0,                  32'd0,     64'h9000,               32'd4096,  7,  7, 1'b1);
        add_vec(1'b1, 64'h20000,              32'd4096,  64'h20000,              32'd4096,  3,  9, 1'b1);
        add_vec(1'b1, 64'hFFFF_FFFF_FFFF_F000, 32'd8192, 64'hFFFF_FFFF_FFFF_F000, 32'd4096,  2,  2, 1'b0);
        add_vec(1'b0, 64'h0,                  32'd0,     64'h0,                  32'd4096,  1,  1, 1'b1);
        add_vec(1'b1, 64'h40,                 32'd4097,  64'h40,                 32'd4096,  2,  2, 1'b0);
        add_vec(1'b0, 64'h0,                  32'd0,     64'h1040,               32'd1,     1,  1, 1'b1);

        repeat (3) @(posedge ap_clk);
        #1;
        areset = 1'b0;
        @(negedge ap_clk);
        #1;
        chk_quiet("reset");

        // Single jobs, multi-chunk splits, done ordering and address wrap.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.new_job) begin
                step();
                push_job(v.job_off, v.job_len, acc);
                exp_start = acc + 3;
            end
            get_start(r);
            chk_start($sformatf("vec%0d", i), r, v.exp_off, v.exp_len, exp_start);
            do_dones(v.rd_dly, v.wr_dly, m);
            if (v.last) begin
                wait_done(d);
                chk_int($sformatf("vec%0d_job_done_cycle", i), d, m + 2);
                jc = jc + 16'd1;
                @(negedge ap_clk);
                #1;
                chk($sformatf("vec%0d_jobs_completed", i), 64'(jobs_completed), 64'(jc));
                chk_int($sformatf("vec%0d_no_extra_start", i), st_q.size(), 0);
            end else begin
                exp_start = m + 2;
            end
        end

        // Queue fill: five back-to-back pushes, then a sixth held while full.
        for (int i = 0; i < 6; i++) begin
            f_off[i] = 64'h10000 + 64'(i * 'h100);
            f_len[i] = 32'(64 * (i + 1));
        end
        n_acc = 0;
        step();
        push_job(f_off[0], f_len[0], d0);
        for (int i = 1; i < 5; i++) begin
            push_job(f_off[i], f_len[i], acc);
            chk_int($sformatf("fifo_push%0d_cycle", i), acc, d0 + i);
        end
        job_offset = f_off[5];
        job_length = f_len[5];
        job_valid  = 1'b1;
        @(negedge ap_clk);
        #1;
        chk("fifo_ready_full", 64'(job_ready), 64'd0);
        chk_int("fifo_accepted_before_pop", n_acc, 5);
        get_start(r);
        chk_start("fifo_job0", r, f_off[0], f_len[0], d0 + 3);
        do_dones(3, 3, m);
        wait_done(d);
        chk_int("fifo_job0_done_cycle", d, m + 2);
        jc = jc + 16'd1;
        step();
        @(negedge ap_clk);
        #1;
        chk("fifo_ready_during_pop", 64'(job_ready), 64'd0);
        chk_int("fifo_not_accepted_during_pop", n_acc, 5);
        step();
        @(negedge ap_clk);
        #1;
        chk("fifo_ready_after_pop", 64'(job_ready), 64'd1);
        chk_int("fifo_accepted_after_pop", n_acc, 6);
        step();
        job_valid = 1'b0;
        for (int i = 1; i < 6; i++) begin
            get_start(r);
            chk_start($sformatf("fifo_job%0d", i), r, f_off[i], f_len[i], (i == 1) ? d + 3 : -1);
            do_dones(2, 1, m);
            wait_done(d);
            chk_int($sformatf("fifo_job%0d_done_cycle", i), d, m + 2);
            jc = jc + 16'd1;
        end
        @(negedge ap_clk);
        #1;
        chk("fifo_jobs_completed", 64'(jobs_completed), 64'(jc));
        chk_int("fifo_total_accepted", n_acc, 6);
        chk_int("fifo_no_extra_start", st_q.size(), 0);

        // Zero-length job between two 64-byte jobs.
        step();
        push_job(64'h3000, 32'd64, acc);
        push_job(64'h3100, 32'd0, acc);
        push_job(64'h3200, 32'd64, acc);
        get_start(r);
        chk_start("zl_first", r, 64'h3000, 32'd64, -1);
        do_dones(2, 2, m);
        wait_done(d0);
        chk_int("zl_first_done_cycle", d0, m + 2);
        wait_done(d);
        chk_int("zl_zero_done_cycle", d, d0 + 3);
        get_start(r);
        chk_start("zl_third", r, 64'h3200, 32'd64, d + 3);
        do_dones(1, 2, m);
        wait_done(d);
        chk_int("zl_third_done_cycle", d, m + 2);
        jc = jc + 16'd3;
        @(negedge ap_clk);
        #1;
        chk("zl_jobs_completed", 64'(jobs_completed), 64'(jc));
        chk_int("zl_no_extra_start", st_q.size(), 0);

        // Reset while waiting on the second chunk of a three-chunk job.
        step();
        push_job(64'h4000, 32'd12288, acc);
        get_start(r);
        chk_start("rst_chunk0", r, 64'h4000, 32'd4096, acc + 3);
        do_dones(2, 2, m);
        get_start(r);
        chk_start("rst_chunk1", r, 64'h5000, 32'd4096, m + 2);
        step();
        chk("rst_busy_before", 64'(busy), 64'd1);
        areset = 1'b1;
        step();
        areset = 1'b0;
        @(negedge ap_clk);
        #1;
        chk_quiet("rst_mid_job");
        jc = '0;
        step();
        rd_ctrl_done = 1'b1;
        step();
        rd_ctrl_done = 1'b0;
        repeat (5) step();
        chk_int("rst_no_start", st_q.size(), 0);
        chk_int("rst_no_job_done", done_q.size(), 0);
        chk("rst_idle_busy", 64'(busy), 64'd0);
        push_job(64'h100, 32'd128, acc);
        get_start(r);
        chk_start("rst_new_job", r, 64'h100, 32'd128, acc + 3);
        do_dones(6, 2, m);
        wait_done(d);
        chk_int("rst_new_job_done_cycle", d, m + 2);
        @(negedge ap_clk);
        #1;
        chk("rst_new_jobs_completed", 64'(jobs_completed), 64'd1);
        chk_int("rst_new_no_extra_start", st_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
